// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: ID-stage control bundle and register fields in, staged controls,
// hazard and forwarding selects out. master = decode/datapath side, slave = ctrl_pipe.
interface ctrl_pipe_if;
  logic       RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp;
  logic [1:0] id_rs, id_rt, id_rd;
  logic       Zero;
  logic       ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch;
  logic       mem_MemRead, mem_MemWrite;
  logic       wb_RegWrite, wb_MemtoReg;
  logic [1:0] wb_WriteReg;
  logic       PCSrc, Stall, Flush;
  logic [1:0] ForwardA, ForwardB;

  modport master (
    output RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp,
    output id_rs, id_rt, id_rd, Zero,
    input  ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch, mem_MemRead, mem_MemWrite,
    input  wb_RegWrite, wb_MemtoReg, wb_WriteReg, PCSrc, Stall, Flush, ForwardA, ForwardB
  );

  modport slave (
    input  RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp,
    input  id_rs, id_rt, id_rd, Zero,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, ex_Branch, mem_MemRead, mem_MemWrite,
    output wb_RegWrite, wb_MemtoReg, wb_WriteReg, PCSrc, Stall, Flush, ForwardA, ForwardB
  );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID->EX->MEM->WB control pipeline with branch flush and load-use stall.
// Define CTRL_PIPE_FORWARD_EN for EX operand forwarding; otherwise stall on any in-flight RAW.
module ctrl_pipe (
  input logic        Clk,
  input logic        Clear,
  ctrl_pipe_if.slave bus
);

  logic       r_RegDst_p0, r_RegWrite_p0, r_ALUSrc_p0, r_Branch_p0;
  logic       r_MemRead_p0, r_MemWrite_p0, r_MemtoReg_p0, r_ALUOp_p0;
  logic [1:0] r_rt_p0, r_rd_p0;
`ifdef CTRL_PIPE_FORWARD_EN
  logic [1:0] r_rs_p0;
`endif
  logic       r_RegWrite_p1, r_MemRead_p1, r_MemWrite_p1, r_MemtoReg_p1;
  logic [1:0] r_dst_p1;
  logic       r_RegWrite_p2, r_MemtoReg_p2;
  logic [1:0] r_dst_p2;

  logic [1:0] w_ex_dst;
  logic       w_pcsrc, w_hazard, w_bubble, w_id_hits_ex;
  logic [1:0] w_fwd_a, w_fwd_b;

  assign w_ex_dst     = r_RegDst_p0 ? r_rd_p0 : r_rt_p0;
  assign w_pcsrc      = r_Branch_p0 & bus.Zero;
  assign w_id_hits_ex = (w_ex_dst == bus.id_rs) | (w_ex_dst == bus.id_rt);

`ifdef CTRL_PIPE_FORWARD_EN
  assign w_hazard = r_MemRead_p0 & r_RegWrite_p0 & w_id_hits_ex;
  // MEM result is newer than WB, so it takes priority
  assign w_fwd_a  = (r_RegWrite_p1 && (r_dst_p1 == r_rs_p0)) ? 2'b10 :
                    (r_RegWrite_p2 && (r_dst_p2 == r_rs_p0)) ? 2'b01 : 2'b00;
  assign w_fwd_b  = (r_RegWrite_p1 && (r_dst_p1 == r_rt_p0)) ? 2'b10 :
                    (r_RegWrite_p2 && (r_dst_p2 == r_rt_p0)) ? 2'b01 : 2'b00;
`else
  logic w_id_hits_mem;
  assign w_id_hits_mem = (r_dst_p1 == bus.id_rs) | (r_dst_p1 == bus.id_rt);
  assign w_hazard = (r_RegWrite_p0 & w_id_hits_ex) | (r_RegWrite_p1 & w_id_hits_mem);
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
`endif

  // a taken branch squashes the ID instruction, which also removes any stall it caused
  assign w_bubble = w_pcsrc | w_hazard;

  // ID -> EX
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      r_RegDst_p0   <= 1'b0;
      r_RegWrite_p0 <= 1'b0;
      r_ALUSrc_p0   <= 1'b0;
      r_Branch_p0   <= 1'b0;
      r_MemRead_p0  <= 1'b0;
      r_MemWrite_p0 <= 1'b0;
      r_MemtoReg_p0 <= 1'b0;
      r_ALUOp_p0    <= 1'b0;
      r_rt_p0       <= 2'b00;
      r_rd_p0       <= 2'b00;
`ifdef CTRL_PIPE_FORWARD_EN
      r_rs_p0       <= 2'b00;
`endif
    end else if (w_bubble) begin
      r_RegDst_p0   <= 1'b0;
      r_RegWrite_p0 <= 1'b0;
      r_ALUSrc_p0   <= 1'b0;
      r_Branch_p0   <= 1'b0;
      r_MemRead_p0  <= 1'b0;
      r_MemWrite_p0 <= 1'b0;
      r_MemtoReg_p0 <= 1'b0;
      r_ALUOp_p0    <= 1'b0;
      r_rt_p0       <= 2'b00;
      r_rd_p0       <= 2'b00;
`ifdef CTRL_PIPE_FORWARD_EN
      r_rs_p0       <= 2'b00;
`endif
    end else begin
      r_RegDst_p0   <= bus.RegDst;
      r_RegWrite_p0 <= bus.RegWrite;
      r_ALUSrc_p0   <= bus.ALUSrc;
      r_Branch_p0   <= bus.Branch;
      r_MemRead_p0  <= bus.MemRead;
      r_MemWrite_p0 <= bus.MemWrite;
      r_MemtoReg_p0 <= bus.MemtoReg;
      r_ALUOp_p0    <= bus.ALUOp;
      r_rt_p0       <= bus.id_rt;
      r_rd_p0       <= bus.id_rd;
`ifdef CTRL_PIPE_FORWARD_EN
      r_rs_p0       <= bus.id_rs;
`endif
    end
  end

  // EX -> MEM and MEM -> WB
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      r_RegWrite_p1 <= 1'b0;
      r_MemRead_p1  <= 1'b0;
      r_MemWrite_p1 <= 1'b0;
      r_MemtoReg_p1 <= 1'b0;
      r_dst_p1      <= 2'b00;
      r_RegWrite_p2 <= 1'b0;
      r_MemtoReg_p2 <= 1'b0;
      r_dst_p2      <= 2'b00;
    end else begin
      r_RegWrite_p1 <= r_RegWrite_p0;
      r_MemRead_p1  <= r_MemRead_p0;
      r_MemWrite_p1 <= r_MemWrite_p0;
      r_MemtoReg_p1 <= r_MemtoReg_p0;
      r_dst_p1      <= w_ex_dst;
      r_RegWrite_p2 <= r_RegWrite_p1;
      r_MemtoReg_p2 <= r_MemtoReg_p1;
      r_dst_p2      <= r_dst_p1;
    end
  end

  assign bus.ex_RegDst    = r_RegDst_p0;
  assign bus.ex_ALUSrc    = r_ALUSrc_p0;
  assign bus.ex_ALUOp     = r_ALUOp_p0;
  assign bus.ex_Branch    = r_Branch_p0;
  assign bus.mem_MemRead  = r_MemRead_p1;
  assign bus.mem_MemWrite = r_MemWrite_p1;
  assign bus.wb_RegWrite  = r_RegWrite_p2;
  assign bus.wb_MemtoReg  = r_MemtoReg_p2;
  assign bus.wb_WriteReg  = r_dst_p2;
  assign bus.PCSrc        = w_pcsrc;
  assign bus.Flush        = w_pcsrc;
  assign bus.Stall        = w_hazard & ~w_pcsrc;
  assign bus.ForwardA     = w_fwd_a;
  assign bus.ForwardB     = w_fwd_b;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed testbench for ctrl_pipe; expectations follow CTRL_PIPE_FORWARD_EN when defined.
module tb_ctrl_pipe;
  logic Clk;
  logic Clear;
  int   n_checks;
  int   n_fail;

  ctrl_pipe_if bus ();
  ctrl_pipe dut (.Clk(Clk), .Clear(Clear), .bus(bus));

  // control order: {RegDst, RegWrite, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp}
  localparam logic [7:0] C_NONE  = 8'b0000_0000;
  localparam logic [7:0] C_RTYPE = 8'b1100_0001;
  localparam logic [7:0] C_LOAD  = 8'b0110_1010;
  localparam logic [7:0] C_BRLD  = 8'b0101_1000;

  logic [16:0] outs;
  logic [3:0]  ex_ctl;
  assign outs = {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_ALUOp, bus.ex_Branch,
                 bus.mem_MemRead, bus.mem_MemWrite, bus.wb_RegWrite, bus.wb_MemtoReg,
                 bus.wb_WriteReg, bus.PCSrc, bus.Stall, bus.Flush, bus.ForwardA, bus.ForwardB};
  assign ex_ctl = {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_ALUOp, bus.ex_Branch};

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_id(input logic [7:0] ctl, input logic [1:0] rs, input logic [1:0] rt,
                        input logic [1:0] rd);
    {bus.RegDst, bus.RegWrite, bus.ALUSrc, bus.Branch,
     bus.MemRead, bus.MemWrite, bus.MemtoReg, bus.ALUOp} = ctl;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    set_id(C_NONE, 2'd0, 2'd0, 2'd0);
    bus.Zero = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    bus.Zero = 1'b1;
    set_id(C_RTYPE, 2'd1, 2'd1, 2'd2);
    repeat (2) tick();
    n_checks++;
    if (outs !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", outs, 17'd0);
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_rtype();
    // Clear released mid-cycle with an R-type already waiting in ID
    #2 Clear = 1'b0;
    tick();
    n_checks++;
    if (ex_ctl !== 4'b1010) begin
      n_fail++;
      $display("FAIL rtype_ex_ctl: got %b want %b", ex_ctl, 4'b1010);
    end
    set_id(C_NONE, 2'd0, 2'd0, 2'd0);
    tick();
    n_checks++;
    if (bus.wb_RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_wb_early: got %b want %b", bus.wb_RegWrite, 1'b0);
    end
    tick();
    n_checks++;
    if ({bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_WriteReg} !== 4'b1010) begin
      n_fail++;
      $display("FAIL rtype_wb: got %b want %b",
               {bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_WriteReg}, 4'b1010);
    end
    tick();
    n_checks++;
    if (bus.wb_RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL rtype_wb_after: got %b want %b", bus.wb_RegWrite, 1'b0);
    end
  endtask

  task automatic test_load_use();
    set_id(C_LOAD, 2'd0, 2'd1, 2'd0);
    tick();
    set_id(C_RTYPE, 2'd1, 2'd0, 2'd2);
    #1;
    n_checks++;
    if ({bus.Stall, bus.Flush, bus.ForwardA} !== 4'b1000) begin
      n_fail++;
      $display("FAIL loaduse_stall: got %b want %b", {bus.Stall, bus.Flush, bus.ForwardA}, 4'b1000);
    end
    tick();
    n_checks++;
    if ({bus.ex_RegDst, bus.mem_MemRead} !== 2'b01) begin
      n_fail++;
      $display("FAIL loaduse_bubble: got %b want %b", {bus.ex_RegDst, bus.mem_MemRead}, 2'b01);
    end
`ifdef CTRL_PIPE_FORWARD_EN
    n_checks++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL loaduse_stall_once: got %b want %b", bus.Stall, 1'b0);
    end
    tick();
    n_checks++;
    if ({bus.ex_RegDst, bus.ForwardA, bus.ForwardB} !== 5'b1_01_00) begin
      n_fail++;
      $display("FAIL loaduse_fwd_wb: got %b want %b",
               {bus.ex_RegDst, bus.ForwardA, bus.ForwardB}, 5'b1_01_00);
    end
`else
    n_checks++;
    if (bus.Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL loaduse_stall_mem: got %b want %b", bus.Stall, 1'b1);
    end
    tick();
    n_checks++;
    if ({bus.Stall, bus.ex_RegDst} !== 2'b00) begin
      n_fail++;
      $display("FAIL loaduse_release: got %b want %b", {bus.Stall, bus.ex_RegDst}, 2'b00);
    end
    tick();
    n_checks++;
    if ({bus.ex_RegDst, bus.ForwardA} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL loaduse_issue: got %b want %b", {bus.ex_RegDst, bus.ForwardA}, 3'b1_00);
    end
`endif
    n_checks++;
    if ({bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_WriteReg} !== 4'b1101 &&
        {bus.wb_RegWrite, bus.wb_MemtoReg} !== 2'b00) begin
      n_fail++;
      $display("FAIL loaduse_wb: got %b", {bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_WriteReg});
    end
    drain();
  endtask

`ifdef CTRL_PIPE_FORWARD_EN
  task automatic test_forward_paths();
    set_id(C_RTYPE, 2'd0, 2'd0, 2'd3);
    tick();
    set_id(C_RTYPE, 2'd1, 2'd1, 2'd3);
    tick();
    set_id(C_RTYPE, 2'd3, 2'd3, 2'd1);
    #1;
    n_checks++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_no_stall: got %b want %b", bus.Stall, 1'b0);
    end
    tick();
    // both MEM and WB hold rd=3; MEM must win
    n_checks++;
    if ({bus.ForwardA, bus.ForwardB} !== 4'b1010) begin
      n_fail++;
      $display("FAIL fwd_mem_prio: got %b want %b", {bus.ForwardA, bus.ForwardB}, 4'b1010);
    end
    set_id(C_RTYPE, 2'd3, 2'd1, 2'd2);
    tick();
    n_checks++;
    if ({bus.ForwardA, bus.ForwardB} !== 4'b0110) begin
      n_fail++;
      $display("FAIL fwd_wb_and_mem: got %b want %b", {bus.ForwardA, bus.ForwardB}, 4'b0110);
    end
    drain();
  endtask
`else
  task automatic test_stall_no_fwd();
    set_id(C_RTYPE, 2'd0, 2'd0, 2'd2);
    tick();
    set_id(C_RTYPE, 2'd2, 2'd0, 2'd1);
    #1;
    n_checks++;
    if ({bus.Stall, bus.ForwardA} !== 3'b1_00) begin
      n_fail++;
      $display("FAIL nofwd_stall1: got %b want %b", {bus.Stall, bus.ForwardA}, 3'b1_00);
    end
    tick();
    n_checks++;
    if ({bus.Stall, bus.ex_RegDst, bus.ForwardA} !== 4'b1_0_00) begin
      n_fail++;
      $display("FAIL nofwd_stall2: got %b want %b", {bus.Stall, bus.ex_RegDst, bus.ForwardA}, 4'b1_0_00);
    end
    tick();
    n_checks++;
    if ({bus.Stall, bus.ex_RegDst} !== 2'b00) begin
      n_fail++;
      $display("FAIL nofwd_release: got %b want %b", {bus.Stall, bus.ex_RegDst}, 2'b00);
    end
    tick();
    n_checks++;
    if ({bus.ex_RegDst, bus.ForwardA, bus.ForwardB} !== 5'b1_00_00) begin
      n_fail++;
      $display("FAIL nofwd_issue: got %b want %b",
               {bus.ex_RegDst, bus.ForwardA, bus.ForwardB}, 5'b1_00_00);
    end
    drain();
  endtask
`endif

  task automatic test_reg0();
    set_id(C_RTYPE, 2'd1, 2'd1, 2'd0);
    tick();
    set_id(C_RTYPE, 2'd0, 2'd0, 2'd1);
    #1;
`ifdef CTRL_PIPE_FORWARD_EN
    n_checks++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reg0_no_stall: got %b want %b", bus.Stall, 1'b0);
    end
    tick();
    n_checks++;
    if ({bus.ForwardA, bus.ForwardB} !== 4'b1010) begin
      n_fail++;
      $display("FAIL reg0_fwd: got %b want %b", {bus.ForwardA, bus.ForwardB}, 4'b1010);
    end
`else
    n_checks++;
    if (bus.Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reg0_stall: got %b want %b", bus.Stall, 1'b1);
    end
`endif
    drain();
  endtask

  task automatic test_flush();
    set_id(C_BRLD, 2'd0, 2'd2, 2'd0);
    tick();
    set_id(C_RTYPE, 2'd2, 2'd0, 2'd1);
    bus.Zero = 1'b0;
    #1;
    n_checks++;
    if ({bus.PCSrc, bus.Flush, bus.Stall} !== 3'b001) begin
      n_fail++;
      $display("FAIL flush_not_taken: got %b want %b", {bus.PCSrc, bus.Flush, bus.Stall}, 3'b001);
    end
    bus.Zero = 1'b1;
    #1;
    n_checks++;
    if ({bus.PCSrc, bus.Flush, bus.Stall} !== 3'b110) begin
      n_fail++;
      $display("FAIL flush_taken: got %b want %b", {bus.PCSrc, bus.Flush, bus.Stall}, 3'b110);
    end
    tick();
    n_checks++;
    if ({ex_ctl, bus.mem_MemRead, bus.PCSrc} !== 6'b0000_1_0) begin
      n_fail++;
      $display("FAIL flush_bubble: got %b want %b", {ex_ctl, bus.mem_MemRead, bus.PCSrc}, 6'b0000_1_0);
    end
    drain();
  endtask

  task automatic test_clear_midflight();
    set_id(C_RTYPE, 2'd0, 2'd0, 2'd1);
    tick();
    set_id(C_RTYPE, 2'd0, 2'd0, 2'd2);
    tick();
    set_id(C_RTYPE, 2'd0, 2'd0, 2'd3);
    tick();
    set_id(C_NONE, 2'd0, 2'd0, 2'd0);
    #1;
    n_checks++;
    if ({bus.ex_RegDst, bus.wb_RegWrite, bus.wb_WriteReg} !== 4'b1101) begin
      n_fail++;
      $display("FAIL clear_inflight: got %b want %b",
               {bus.ex_RegDst, bus.wb_RegWrite, bus.wb_WriteReg}, 4'b1101);
    end
    #1 Clear = 1'b1;
    #1;
    // still in the high phase: no edge has occurred since Clear rose
    n_checks++;
    if (outs !== 17'd0) begin
      n_fail++;
      $display("FAIL clear_async: got %h want %h", outs, 17'd0);
    end
    tick();
    #2 Clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({bus.wb_RegWrite, bus.ex_RegDst} !== 2'b00) begin
        n_fail++;
        $display("FAIL clear_no_wb[%0d]: got %b want %b", i, {bus.wb_RegWrite, bus.ex_RegDst}, 2'b00);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rtype();
    test_load_use();
`ifdef CTRL_PIPE_FORWARD_EN
    test_forward_paths();
`else
    test_stall_no_fwd();
`endif
    test_reg0();
    test_flush();
    test_clear_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
